load_store_unit: RTL and testbench

//  Initiator side of the single-port word memory interface (byte addr A, WD, We, async RD, write on posedge).

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_align.sv | 27 ++
 rtl/load_store_unit.sv | 98 +++++++++
 tb/tb_load_store_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size encodings, FSM states and request legality checks shared by the LSU.
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_e;

   function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr);
      return ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) || (funct3 == F3_W && addr != 2'b00);
   endfunction

   // Unsigned variants only make sense for loads.
   function automatic logic illegal(input logic we, input logic [2:0] funct3);
      return funct3 == 3'b011 || funct3[2:1] == 2'b11 || (we && funct3[2]);
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: lane extraction with sign/zero extension for loads and lane merge for sub-word stores.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] rbuf_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_i,
   output logic [31:0] rdata_o,
   output logic [31:0] wd_o
);
   logic [31:0] byte_w, half_w, mask, wshift;
   always_comb begin
      byte_w  = rbuf_i >> {addr_i, 3'b000};
      half_w  = rbuf_i >> {addr_i[1], 4'b0000};
      rdata_o = funct3_i == F3_B  ? {{24{byte_w[7]}}, byte_w[7:0]} :
                funct3_i == F3_H  ? {{16{half_w[15]}}, half_w[15:0]} :
                funct3_i == F3_W  ? rbuf_i :
                funct3_i == F3_BU ? {24'd0, byte_w[7:0]} :
                funct3_i == F3_HU ? {16'd0, half_w[15:0]} : '0;
      mask    = funct3_i == F3_B ? 32'h0000_00ff << {addr_i, 3'b000} :
                funct3_i == F3_H ? 32'h0000_ffff << {addr_i[1], 4'b0000} : 32'hffff_ffff;
      wshift  = funct3_i == F3_B ? wdata_i << {addr_i, 3'b000} :
                funct3_i == F3_H ? wdata_i << {addr_i[1], 4'b0000} : wdata_i;
      wd_o    = (rbuf_i & ~mask) | (wshift & mask);
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns one CPU load/store into cycles on a single-port word memory,
// using read-modify-write for sub-word stores.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_A,
   output logic [DATA_W-1:0] mem_WD,
   output logic              mem_We,
   input  logic [DATA_W-1:0] mem_RD
);
   state_e            state_q, state_d;
   logic              we_q, we_d, err_q, err_d, req_err;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rbuf_q, rbuf_d, rdata, wd;

   lsu_align u_align (
      .rbuf_i  (rbuf_q),
      .wdata_i (wdata_q),
      .funct3_i(f3_q),
      .addr_i  (addr_q[1:0]),
      .rdata_o (rdata),
      .wd_o    (wd)
   );

   assign req_err = misaligned(req_funct3, req_addr[1:0]) || illegal(req_we, req_funct3);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         err_q   <= err_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      err_d   = err_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rbuf_d  = rbuf_q;
      unique case (state_q)
         S_IDLE: if (req_valid) begin
            we_d    = req_we;
            err_d   = req_err;
            f3_d    = req_funct3;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            state_d = req_err ? S_RESP : S_ACCESS;
         end
         S_ACCESS: begin
            rbuf_d  = mem_RD;
            state_d = we_q ? S_WRITE : S_RESP;
         end
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
      endcase
   end

   // Write is gated by rst so a reset landing in WRITE never corrupts memory.
   always_comb begin
      req_ready  = state_q == S_IDLE;
      mem_A      = state_q == S_IDLE ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
      mem_We     = state_q == S_WRITE && !rst;
      mem_WD     = state_q == S_WRITE ? wd : '0;
      resp_valid = state_q == S_RESP;
      resp_err   = resp_valid && err_q;
      resp_rdata = resp_valid && !err_q && !we_q ? rdata : '0;
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store/error/reset sequence against a word memory model,
// with expected responses queued at drive time and popped on resp_valid.
module tb_load_store_unit;
   import lsu_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      logic        wr;
      logic [31:0] wd;
   } exp_t;

   logic        clk = 0, rst = 1;
   logic        req_valid = 0, req_we = 0;
   logic [2:0]  req_funct3 = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic        req_ready, resp_valid, resp_err, mem_We;
   logic [31:0] resp_rdata, mem_A, mem_WD, mem_RD;
   logic [31:0] mem [0:15];
   exp_t        sb[$];
   int          total = 0, bad = 0;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_A(mem_A), .mem_WD(mem_WD), .mem_We(mem_We), .mem_RD(mem_RD)
   );

   always #5 clk = ~clk;
   assign mem_RD = mem[mem_A[5:2]];
   always @(posedge clk) if (mem_We) mem[mem_A[5:2]] <= mem_WD;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wdat, input logic [31:0] e_rd, input logic e_err,
                      input int e_lat, input logic e_wr, input logic [31:0] e_wd);
      exp_t e;
      int lat = 0, nwe = 0, wcyc = 0;
      logic [31:0] got_wd = 0;
      logic done = 0;
      @(negedge clk);
      req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wdat;
      sb.push_back('{e_rd, e_err, e_lat, e_wr, e_wd});
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 0; req_we = ~we; req_funct3 = F3_W; req_addr = $urandom; req_wdata = $urandom;
      for (int c = 1; c <= 8 && !done; c++) begin
         @(negedge clk);
         if (c == 1 && !e_err) chk({tag, "_memA"}, mem_A, {a[31:2], 2'b00});
         if (mem_We) begin nwe++; got_wd = mem_WD; wcyc = c; end
         if (resp_valid) begin done = 1; lat = c; end
      end
      e = sb.pop_front();
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
      chk({tag, "_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
      chk({tag, "_nwe"}, 32'(nwe), 32'(e.wr));
      if (e.wr) begin
         chk({tag, "_wd"}, got_wd, e.wd);
         chk({tag, "_wcyc"}, 32'(wcyc), 32'(e.lat - 1));
      end
   endtask

   task automatic b2b(input string tag, input logic we, input int gap, input int n_exp);
      int prev = -1, n = 0;
      @(negedge clk);
      req_valid = 1; req_we = we; req_funct3 = F3_W; req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         if (req_ready) begin
            if (prev >= 0) chk({tag, "_gap"}, 32'(c - prev), 32'(gap));
            prev = c; n++;
         end
      end
      req_valid = 0;
      chk({tag, "_count"}, 32'(n), 32'(n_exp));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[2] = 32'h8899AABB;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_we", 32'(mem_We), 32'd0);
      chk("rst_A", mem_A, 32'd0);
      chk("rst_WD", mem_WD, 32'd0);

      run("lb_0b",  0, F3_B,  32'h0B, 0, 32'hFFFFFF88, 0, 2, 0, 0);
      run("lbu_0b", 0, F3_BU, 32'h0B, 0, 32'h00000088, 0, 2, 0, 0);
      run("lb_08",  0, F3_B,  32'h08, 0, 32'hFFFFFFBB, 0, 2, 0, 0);
      run("lbu_09", 0, F3_BU, 32'h09, 0, 32'h000000AA, 0, 2, 0, 0);
      run("lh_08",  0, F3_H,  32'h08, 0, 32'hFFFFAABB, 0, 2, 0, 0);
      run("lh_0a",  0, F3_H,  32'h0A, 0, 32'hFFFF8899, 0, 2, 0, 0);
      run("lhu_0a", 0, F3_HU, 32'h0A, 0, 32'h00008899, 0, 2, 0, 0);
      run("lw_08",  0, F3_W,  32'h08, 0, 32'h8899AABB, 0, 2, 0, 0);

      run("sb_09",  1, F3_B,  32'h09, 32'h123456CC, 0, 0, 3, 1, 32'h8899CCBB);
      run("lw_sb",  0, F3_W,  32'h08, 0, 32'h8899CCBB, 0, 2, 0, 0);
      mem[2] = 32'h8899AABB;
      run("sh_0a",  1, F3_H,  32'h0A, 32'h0000BEEF, 0, 0, 3, 1, 32'hBEEFAABB);
      chk("sh_mem", mem[2], 32'hBEEFAABB);
      mem[2] = 32'h8899AABB;
      run("sw_08",  1, F3_W,  32'h08, 32'hDEADBEEF, 0, 0, 3, 1, 32'hDEADBEEF);
      chk("sw_mem", mem[2], 32'hDEADBEEF);
      mem[2] = 32'h8899AABB;

      run("e_lw06", 0, F3_W,   32'h06, 0, 0, 1, 1, 0, 0);
      run("e_sh05", 1, F3_H,   32'h05, 32'h1111, 0, 1, 1, 0, 0);
      run("e_f011", 0, 3'b011, 32'h08, 0, 0, 1, 1, 0, 0);
      run("e_sbu",  1, F3_BU,  32'h08, 32'h22, 0, 1, 1, 0, 0);
      run("e_f110", 0, 3'b110, 32'h08, 0, 0, 1, 1, 0, 0);
      chk("err_mem", mem[2], 32'h8899AABB);

      @(negedge clk);
      req_valid = 1; req_we = 1; req_funct3 = F3_B; req_addr = 32'h09; req_wdata = 32'h123456CC;
      @(posedge clk); #1 req_valid = 0;
      @(posedge clk); #1 rst = 1;
      @(negedge clk);
      chk("rstw_we", 32'(mem_We), 32'd0);
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("rstw_ready", 32'(req_ready), 32'd1);
      chk("rstw_valid", 32'(resp_valid), 32'd0);
      chk("rstw_mem", mem[2], 32'h8899AABB);
      @(negedge clk);
      chk("rstw_valid2", 32'(resp_valid), 32'd0);

      b2b("b2b_ld", 0, 3, 4);
      b2b("b2b_st", 1, 4, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
